rggen_bus_initiator: RTL and testbench

Drives the host side of the register-block bus interface `rggen_bus_if`: it accepts one register access command on a valid/ready stream, issues it on `bus_if`, and returns status and read data on a valid/ready response stream. It is the initiator counterpart of the register responders. It sits between a CPU/DMA/test sequencer and the register-block adapter, and it makes exactly one outstanding access at a time.

---
 rtl/rggen_bus_initiator_pkg.sv | 31 +++
 rtl/rggen_bus_initiator_if.sv | 28 ++
 rtl/rggen_bus_initiator_watchdog.sv | 34 +++
 rtl/rggen_bus_initiator.sv | 144 ++++++++++++++
 tb/tb_rggen_bus_initiator.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_bus_initiator_pkg.sv
// Shared register-bus access/status encodings plus initiator-local helpers.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

package rggen_bus_initiator_pkg;

    import rggen_rtl_pkg::*;

    function automatic rggen_access cmd_to_access(input logic write);
        if (write) begin
            return RGGEN_WRITE;
        end else begin
            return RGGEN_READ;
        end
    endfunction

endpackage

// File: rtl/rggen_bus_initiator_if.sv
// Register-block bus: the initiator drives the master side, adapters the slave side.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);

    logic                       valid;
    rggen_access                access;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       ready;
    rggen_status                status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );

endinterface

// File: rtl/rggen_bus_initiator_watchdog.sv
// Access watchdog: counts ISSUE cycles without ready and flags the final one.
module rggen_bus_initiator_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // A ready in the final cycle suppresses expiry so the real completion wins.
    assign o_expired = i_active && !i_ready && (r_count == LAST_COUNT);

    // Wait-cycle counter, cleared as each access is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_active && !i_ready && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/rggen_bus_initiator.sv
// Single-outstanding register bus initiator: command stream in, bus access, response stream out.
// Optional access watchdog enabled by defining RGGEN_BUS_INITIATOR_TIMEOUT_EN.
module rggen_bus_initiator
    import rggen_rtl_pkg::*;
    import rggen_bus_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]    i_cmd_address,
    input  logic [BUS_WIDTH-1:0]        i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]      i_cmd_strobe,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [1:0]                  o_rsp_status,
    output logic [BUS_WIDTH-1:0]        o_rsp_read_data,
    rggen_bus_if.master                 bus_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    localparam int ADDR_LSB = $clog2(BUS_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~ADDRESS_WIDTH'((32'd1 << ADDR_LSB) - 32'd1);

    if ((BUS_WIDTH % 8) != 0) begin : g_bad_bus_width
        $error("rggen_bus_initiator: BUS_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rggen_bus_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    state_e                     r_state;
    logic                       r_cmd_ready;
    logic                       r_bus_valid;
    rggen_access                r_access;
    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic [BUS_WIDTH-1:0]       r_write_data;
    logic [BUS_WIDTH/8-1:0]     r_strobe;
    logic                       r_rsp_valid;
    rggen_status                r_rsp_status;
    logic [BUS_WIDTH-1:0]       r_rsp_read_data;
    logic                       w_timeout;

`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
    rggen_bus_initiator_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_cmd_valid && r_cmd_ready),
        .i_active   (r_state == ST_ISSUE),
        .i_ready    (bus_if.ready),
        .o_expired  (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Access FSM; every output is a register updated alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_cmd_ready     <= 1'b1;
            r_bus_valid     <= 1'b0;
            r_access        <= rggen_access'(2'b00);
            r_address       <= '0;
            r_write_data    <= '0;
            r_strobe        <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_status    <= RGGEN_OKAY;
            r_rsp_read_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_state      <= ST_ISSUE;
                        r_cmd_ready  <= 1'b0;
                        r_bus_valid  <= 1'b1;
                        r_access     <= cmd_to_access(i_cmd_write);
                        r_address    <= i_cmd_address & ADDR_MASK;
                        r_write_data <= i_cmd_write_data;
                        r_strobe     <= i_cmd_strobe;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (bus_if.ready) begin
                        r_state         <= ST_RESP;
                        r_bus_valid     <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_status    <= bus_if.status;
                        r_rsp_read_data <= (r_access == RGGEN_READ) ? bus_if.read_data : '0;
                    end else if (w_timeout) begin
                        r_state         <= ST_RESP;
                        r_bus_valid     <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_status    <= RGGEN_SLAVE_ERROR;
                        r_rsp_read_data <= '0;
                    end else begin
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_bus_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready       = r_cmd_ready;
    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_status      = r_rsp_status;
    assign o_rsp_read_data   = r_rsp_read_data;
    assign bus_if.valid      = r_bus_valid;
    assign bus_if.access     = r_access;
    assign bus_if.address    = r_address;
    assign bus_if.write_data = r_write_data;
    assign bus_if.strobe     = r_strobe;

endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Directed, table-driven bench for rggen_bus_initiator plus multi-cycle corner sequences.
module tb_rggen_bus_initiator;

    import rggen_rtl_pkg::*;

    localparam int AW = 8;
    localparam int BW = 32;
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
    localparam int LONG_WAIT = 3;
`else
    localparam int LONG_WAIT = 5;
`endif

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wait_cycles;
        logic [1:0]  status;
        logic [31:0] rdata;
        logic [7:0]  exp_addr;
        logic [1:0]  exp_access;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_write = 1'b0;
    logic [AW-1:0]  cmd_address = '0;
    logic [BW-1:0]  cmd_write_data = '0;
    logic [3:0]     cmd_strobe = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_status;
    logic [BW-1:0]  rsp_read_data;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[4];

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if();

    rggen_bus_initiator #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_write      (cmd_write),
        .i_cmd_address    (cmd_address),
        .i_cmd_write_data (cmd_write_data),
        .i_cmd_strobe     (cmd_strobe),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_status     (rsp_status),
        .o_rsp_read_data  (rsp_read_data),
        .bus_if           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        cmd_valid      = 1'b1;
        cmd_write      = wr;
        cmd_address    = addr;
        cmd_write_data = wdata;
        cmd_strobe     = strb;
        tick();
        cmd_valid      = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        check($sformatf("v%0d_cmd_ready_idle", idx), cmd_ready, 1);
        issue_cmd(v.write, v.addr, v.wdata, v.strb);
        check($sformatf("v%0d_bus_valid", idx), bus_if.valid, 1);
        check($sformatf("v%0d_cmd_ready_busy", idx), cmd_ready, 0);
        check($sformatf("v%0d_address", idx), bus_if.address, v.exp_addr);
        check($sformatf("v%0d_access", idx), bus_if.access, v.exp_access);
        check($sformatf("v%0d_write_data", idx), bus_if.write_data, v.wdata);
        check($sformatf("v%0d_strobe", idx), bus_if.strobe, v.strb);
        for (int i = 0; i < v.wait_cycles; i++) begin
            tick();
            check($sformatf("v%0d_valid_wait%0d", idx, i), bus_if.valid, 1);
            check($sformatf("v%0d_addr_wait%0d", idx, i), bus_if.address, v.exp_addr);
            check($sformatf("v%0d_rsp_valid_wait%0d", idx, i), rsp_valid, 0);
        end
        bus_if.ready     = 1'b1;
        bus_if.status    = rggen_status'(v.status);
        bus_if.read_data = v.rdata;
        tick();
        bus_if.ready     = 1'b0;
        bus_if.read_data = 32'h0000_0000;
        check($sformatf("v%0d_valid_dropped", idx), bus_if.valid, 0);
        check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
        check($sformatf("v%0d_rsp_status", idx), rsp_status, v.exp_status);
        check($sformatf("v%0d_rsp_data", idx), rsp_read_data, v.exp_data);
        check($sformatf("v%0d_cmd_ready_resp", idx), cmd_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_valid_done", idx), rsp_valid, 0);
        check($sformatf("v%0d_cmd_ready_done", idx), cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t rv;
        bus_if.ready     = 1'b0;
        bus_if.status    = RGGEN_OKAY;
        bus_if.read_data = 32'h0000_0000;

        vecs[0] = '{1'b1, 8'h13, 32'hA5A5_0001, 4'hF, 0, 2'b00, 32'h1234_5678,
                    8'h10, 2'b11, 2'b00, 32'h0000_0000};
        vecs[1] = '{1'b0, 8'h20, 32'h0000_0000, 4'hF, LONG_WAIT, 2'b00, 32'hDEAD_BEEF,
                    8'h20, 2'b10, 2'b00, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 8'h37, 32'h1122_3344, 4'h3, 1, 2'b11, 32'hCAFE_F00D,
                    8'h34, 2'b10, 2'b11, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 8'hFF, 32'h0F0F_F0F0, 4'h8, 2, 2'b10, 32'h5555_AAAA,
                    8'hFC, 2'b11, 2'b10, 32'h0000_0000};

        // Reset values
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_bus_valid", bus_if.valid, 0);
        check("rst_access", bus_if.access, 0);
        check("rst_address", bus_if.address, 0);
        check("rst_write_data", bus_if.write_data, 0);
        check("rst_strobe", bus_if.strobe, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_data", rsp_read_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k], k);
        end

        // Backpressure: response held while a new command waits
        issue_cmd(1'b0, 8'h44, 32'h0, 4'hF);
        bus_if.ready     = 1'b1;
        bus_if.status    = RGGEN_OKAY;
        bus_if.read_data = 32'h0BAD_F00D;
        tick();
        bus_if.ready     = 1'b0;
        cmd_valid        = 1'b1;
        cmd_write        = 1'b1;
        cmd_address      = 8'h0A;
        cmd_write_data   = 32'h7777_0000;
        cmd_strobe       = 4'h1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus_if.ready  = 1'b1;
                bus_if.status = RGGEN_DECODE_ERROR;
            end else begin
                bus_if.ready  = 1'b0;
            end
            check($sformatf("bp_cmd_ready_%0d", i), cmd_ready, 0);
            check($sformatf("bp_rsp_valid_%0d", i), rsp_valid, 1);
            check($sformatf("bp_rsp_status_%0d", i), rsp_status, 2'b00);
            check($sformatf("bp_rsp_data_%0d", i), rsp_read_data, 32'h0BAD_F00D);
            tick();
        end
        bus_if.ready  = 1'b0;
        bus_if.status = RGGEN_OKAY;
        check("bp_rsp_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_cmd_ready_after", cmd_ready, 1);
        check("bp_bus_idle_after", bus_if.valid, 0);
        tick();
        cmd_valid = 1'b0;
        check("bp_new_cmd_valid", bus_if.valid, 1);
        check("bp_new_cmd_addr", bus_if.address, 8'h08);
        check("bp_new_cmd_access", bus_if.access, 2'b11);
        bus_if.ready = 1'b1;
        tick();
        bus_if.ready = 1'b0;
        check("bp_new_rsp_data", rsp_read_data, 32'h0000_0000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
        // Watchdog abort with a late ready afterwards
        issue_cmd(1'b0, 8'h60, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("to_valid_%0d", i), bus_if.valid, 1);
            tick();
        end
        check("to_valid_3", bus_if.valid, 1);
        tick();
        check("to_valid_dropped", bus_if.valid, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_status", rsp_status, 2'b10);
        check("to_rsp_data", rsp_read_data, 32'h0);
        tick();
        bus_if.ready     = 1'b1;
        bus_if.status    = RGGEN_OKAY;
        bus_if.read_data = 32'hFFFF_FFFF;
        tick();
        bus_if.ready     = 1'b0;
        check("to_late_ready_status", rsp_status, 2'b10);
        check("to_late_ready_data", rsp_read_data, 32'h0);
        check("to_late_ready_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("to_cmd_ready_after", cmd_ready, 1);
`endif

        // Reset pulse in the middle of an access
        issue_cmd(1'b0, 8'h50, 32'h0, 4'hF);
        check("mid_rst_valid_before", bus_if.valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_async", bus_if.valid, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus_if.ready     = 1'b1;
        bus_if.read_data = 32'h1357_9BDF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_no_rsp_%0d", i), rsp_valid, 0);
            check($sformatf("post_rst_no_valid_%0d", i), bus_if.valid, 0);
        end
        bus_if.ready = 1'b0;
        rv = '{1'b0, 8'h52, 32'h0, 4'hF, 1, 2'b00, 32'h2468_ACE0,
               8'h50, 2'b10, 2'b00, 32'h2468_ACE0};
        run_vec(rv, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
